// File: rtl/bcm_sweep_ctrl.sv
// bcm_sweep_ctrl: built-in self-check sequencer for the bcm 3-in/2-out cell.
// Walks all eight input codes through an embedded bcm, captures {o1,o0} for
// each into a packed truth table, and scores the table against EXPECTED.
module bcm_sweep_ctrl #(
    parameter int unsigned   SETTLE   = 1,         // wait cycles per code, 1..15
    parameter logic [15:0]   EXPECTED = 16'h0E3F   // golden {o1,o0} per code
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [2:0]  code_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] table_o,
    output logic [3:0]  mismatch_cnt_o,
    output logic        fail_valid_o,
    output logic [2:0]  first_fail_o
);

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  code_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] table_q;
    logic [3:0]  mismatch_cnt_q;
    logic        fail_valid_q;
    logic [2:0]  first_fail_q;

    // Embedded bcm cell, driven straight from the code register.
    logic [1:0]  bcm_out;   // {o1, o0}
    logic [1:0]  exp_slice;
    logic        sample;
    logic        mismatch;
    logic [3:0]  mismatch_cnt_next;

    // bcm cell logic: o1/o0 as a function of {i2,i1,i0}.
    always_comb begin
        bcm_out = 2'b00;
        unique case (code_q)
            3'd0:    bcm_out = 2'b11;
            3'd1:    bcm_out = 2'b11;
            3'd2:    bcm_out = 2'b11;
            3'd3:    bcm_out = 2'b00;
            3'd4:    bcm_out = 2'b10;
            3'd5:    bcm_out = 2'b11;
            3'd6:    bcm_out = 2'b00;
            3'd7:    bcm_out = 2'b00;
            default: bcm_out = 2'b00;
        endcase
    end

    // Sample-edge decode and scoring of the current code against the golden slice.
    always_comb begin
        exp_slice         = EXPECTED[{code_q, 1'b0} +: 2];
        sample            = (cnt_q == SettleCnt);
        mismatch          = (bcm_out != exp_slice);
        // Count including the code being sampled now, so the last code counts toward pass.
        mismatch_cnt_next = mismatch_cnt_q + 4'(mismatch);
    end

    // Sweep FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            cnt_q          <= 4'd0;
            code_q         <= 3'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            table_q        <= 16'h0000;
            mismatch_cnt_q <= 4'd0;
            fail_valid_q   <= 1'b0;
            first_fail_q   <= 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    // abort beats a simultaneous start
                    if (start_i && !abort_i) begin
                        state_q        <= StRun;
                        cnt_q          <= 4'd0;
                        code_q         <= 3'd0;
                        busy_q         <= 1'b1;
                        pass_q         <= 1'b0;
                        table_q        <= 16'h0000;
                        mismatch_cnt_q <= 4'd0;
                        fail_valid_q   <= 1'b0;
                        first_fail_q   <= 3'd0;
                    end
                end

                StRun: begin
                    if (abort_i) begin
                        // Partial results stay visible; only the run itself is cancelled.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        cnt_q   <= 4'd0;
                        code_q  <= 3'd0;
                    end else if (sample) begin
                        table_q[{code_q, 1'b0} +: 2] <= bcm_out;
                        if (mismatch) begin
                            mismatch_cnt_q <= mismatch_cnt_next;
                            if (!fail_valid_q) begin
                                fail_valid_q <= 1'b1;
                                first_fail_q <= code_q;
                            end
                        end
                        cnt_q <= 4'd0;
                        if (code_q == 3'd7) begin
                            state_q <= StFin;
                            code_q  <= 3'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mismatch_cnt_next == 4'd0);
                        end else begin
                            code_q <= code_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                StFin: begin
                    // Single-cycle done pulse; start/abort deliberately ignored here.
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        code_o         = code_q;
        busy_o         = busy_q;
        done_o         = done_q;
        pass_o         = pass_q;
        table_o        = table_q;
        mismatch_cnt_o = mismatch_cnt_q;
        fail_valid_o   = fail_valid_q;
        first_fail_o   = first_fail_q;
    end

endmodule

// File: tb/tb_bcm_sweep_ctrl.sv
// Bench for bcm_sweep_ctrl: two instances (default, and SETTLE=3 with a
// deliberately wrong golden table), checked cycle by cycle against a model
// derived from the sweep timing rules and the bcm truth table.
module tb_bcm_sweep_ctrl;

    // Truth table of the bcm cell as the bench understands it.
    localparam logic [15:0] BCM_TT = 16'h0E3F;

    logic clk;
    logic rst;
    logic st;
    logic ab;
    logic sel_b;

    logic [2:0]  a_code, b_code, m_code;
    logic        a_busy, b_busy, m_busy;
    logic        a_done, b_done, m_done;
    logic        a_pass, b_pass, m_pass;
    logic [15:0] a_table, b_table, m_table;
    logic [3:0]  a_mc, b_mc, m_mc;
    logic        a_fv, b_fv, m_fv;
    logic [2:0]  a_ff, b_ff, m_ff;

    int total;
    int bad;

    bcm_sweep_ctrl u_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (st & ~sel_b),
        .abort_i        (ab & ~sel_b),
        .code_o         (a_code),
        .busy_o         (a_busy),
        .done_o         (a_done),
        .pass_o         (a_pass),
        .table_o        (a_table),
        .mismatch_cnt_o (a_mc),
        .fail_valid_o   (a_fv),
        .first_fail_o   (a_ff)
    );

    bcm_sweep_ctrl #(
        .SETTLE   (3),
        .EXPECTED (16'h0E3C)
    ) u_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (st & sel_b),
        .abort_i        (ab & sel_b),
        .code_o         (b_code),
        .busy_o         (b_busy),
        .done_o         (b_done),
        .pass_o         (b_pass),
        .table_o        (b_table),
        .mismatch_cnt_o (b_mc),
        .fail_valid_o   (b_fv),
        .first_fail_o   (b_ff)
    );

    assign m_code  = sel_b ? b_code  : a_code;
    assign m_busy  = sel_b ? b_busy  : a_busy;
    assign m_done  = sel_b ? b_done  : a_done;
    assign m_pass  = sel_b ? b_pass  : a_pass;
    assign m_table = sel_b ? b_table : a_table;
    assign m_mc    = sel_b ? b_mc    : a_mc;
    assign m_fv    = sel_b ? b_fv    : a_fv;
    assign m_ff    = sel_b ? b_ff    : a_ff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; leave time 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on the selected instance. abort_at = 0 means no abort; otherwise
    // abort is held during cycle T0+abort_at. noise sprinkles start pulses while
    // the block should be ignoring them.
    task automatic do_sweep(input bit b, input int abort_at, input bit noise, input string nm);
        int          s;
        logic [15:0] ex;
        logic [15:0] tt;
        logic [15:0] et;
        int          n;
        int          emc;
        bit          efv;
        int          eff;
        bit          epass;
        int          fin_c;
        int          end_c;
        int          last_c;
        bit          xb;
        bit          xd;

        sel_b = b;
        s     = b ? 3 : 1;
        ex    = b ? 16'h0E3C : 16'h0E3F;
        tt    = BCM_TT;

        // Codes whose sample edge strictly precedes the abort edge are captured.
        n = 0;
        for (int k = 0; k < 8; k++)
            if (abort_at == 0 || (k + 1) * (s + 1) < abort_at) n++;
        et  = 16'h0000;
        emc = 0;
        efv = 1'b0;
        eff = 0;
        for (int k = 0; k < n; k++) begin
            et[2*k +: 2] = tt[2*k +: 2];
            if (tt[2*k +: 2] != ex[2*k +: 2]) begin
                emc++;
                if (!efv) begin
                    efv = 1'b1;
                    eff = k;
                end
            end
        end
        epass  = (abort_at == 0) && (emc == 0);
        fin_c  = 8 * (s + 1) + 1;
        end_c  = (abort_at != 0) ? abort_at : 8 * (s + 1);
        last_c = (abort_at != 0) ? abort_at : fin_c;

        st = 1'b1;
        ab = 1'b0;
        tick();  // edge T0
        st = 1'b0;

        for (int c = 1; c <= last_c + 2; c++) begin
            xb = (c <= end_c);
            xd = (abort_at == 0) && (c == fin_c);
            total++;
            if (m_busy !== xb) begin
                bad++;
                $display("FAIL %s busy c=%0d got=%b want=%b", nm, c, m_busy, xb);
            end
            total++;
            if (m_done !== xd) begin
                bad++;
                $display("FAIL %s done c=%0d got=%b want=%b", nm, c, m_done, xd);
            end
            if (xb) begin
                total++;
                if (m_code !== 3'((c - 1) / (s + 1))) begin
                    bad++;
                    $display("FAIL %s code c=%0d got=%0d want=%0d", nm, c, m_code,
                             (c - 1) / (s + 1));
                end
            end else begin
                total++;
                if (m_table !== et) begin
                    bad++;
                    $display("FAIL %s table c=%0d got=%h want=%h", nm, c, m_table, et);
                end
                total++;
                if (m_mc !== 4'(emc)) begin
                    bad++;
                    $display("FAIL %s mismatch_cnt c=%0d got=%0d want=%0d", nm, c, m_mc, emc);
                end
                total++;
                if (m_fv !== efv) begin
                    bad++;
                    $display("FAIL %s fail_valid c=%0d got=%b want=%b", nm, c, m_fv, efv);
                end
                if (efv) begin
                    total++;
                    if (m_ff !== 3'(eff)) begin
                        bad++;
                        $display("FAIL %s first_fail c=%0d got=%0d want=%0d", nm, c, m_ff, eff);
                    end
                end
                total++;
                if (m_pass !== epass) begin
                    bad++;
                    $display("FAIL %s pass c=%0d got=%b want=%b", nm, c, m_pass, epass);
                end
            end
            ab = (abort_at != 0) && (c == abort_at);
            st = noise && (c <= last_c) && ($urandom_range(0, 2) == 0);
            tick();
        end
        st = 1'b0;
        ab = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st  = 1'b0;
        ab  = 1'b0;
        tick();
        tick();
        total++;
        if ({a_code, a_busy, a_done, a_pass, a_table, a_mc, a_fv, a_ff} !== 31'd0) begin
            bad++;
            $display("FAIL reset_a got=%h want=0",
                     {a_code, a_busy, a_done, a_pass, a_table, a_mc, a_fv, a_ff});
        end
        total++;
        if ({b_code, b_busy, b_done, b_pass, b_table, b_mc, b_fv, b_ff} !== 31'd0) begin
            bad++;
            $display("FAIL reset_b got=%h want=0",
                     {b_code, b_busy, b_done, b_pass, b_table, b_mc, b_fv, b_ff});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_busy i=%0d got=%b%b want=00", i, a_busy, b_busy);
            end
        end
    endtask

    task automatic test_default_sweep();
        do_sweep(1'b0, 0, 1'b0, "default");
    endtask

    task automatic test_forced_mismatch();
        do_sweep(1'b1, 0, 1'b0, "mismatch");
    endtask

    task automatic test_abort();
        do_sweep(1'b0, 7, 1'b0, "abort7");
        for (int i = 0; i < 4; i++) begin
            do_sweep(1'b0, int'($urandom_range(1, 16)), 1'b0, "abort_rand_a");
            do_sweep(1'b1, int'($urandom_range(1, 32)), 1'b0, "abort_rand_b");
        end
    endtask

    task automatic test_collisions();
        sel_b = 1'b0;
        st    = 1'b1;
        ab    = 1'b1;
        tick();
        st = 1'b0;
        ab = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (a_busy !== 1'b0) begin
                bad++;
                $display("FAIL start_abort_idle i=%0d got=%b want=0", i, a_busy);
            end
            tick();
        end
        do_sweep(1'b0, 0, 1'b1, "start_noise_a");
        do_sweep(1'b1, 0, 1'b1, "start_noise_b");
    endtask

    task automatic test_back_to_back();
        do_sweep(1'b1, 0, 1'b0, "b2b_full");
        // Early abort right after a failing sweep: old results must be gone.
        do_sweep(1'b1, 1, 1'b0, "b2b_clear");
        do_sweep(1'b0, 0, 1'b0, "b2b_a1");
        do_sweep(1'b0, 0, 1'b0, "b2b_a2");
    endtask

    task automatic test_reset_mid();
        sel_b = 1'b0;
        st    = 1'b1;
        tick();  // edge T0
        st = 1'b0;
        st = 1'b0;
        for (int i = 0; i < 8; i++) tick();  // now in cycle T0+9
        rst = 1'b1;
        tick();
        total++;
        if ({a_code, a_busy, a_done, a_pass, a_table, a_mc, a_fv, a_ff} !== 31'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0",
                     {a_code, a_busy, a_done, a_pass, a_table, a_mc, a_fv, a_ff});
        end
        rst = 1'b0;
        tick();
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle got=%b want=0", a_busy);
        end
        do_sweep(1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 6; i++) begin
            bit b;
            int a;
            b = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, b ? 32 : 16));
            do_sweep(b, a, 1'($urandom_range(0, 1)), "random_mix");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel_b = 1'b0;
        st    = 1'b0;
        ab    = 1'b0;
        rst   = 1'b1;
        #1;
        test_reset();
        test_default_sweep();
        test_forced_mismatch();
        test_abort();
        test_collisions();
        test_back_to_back();
        test_reset_mid();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
